// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the t03 instruction fetch stage.
package t03_fetch_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMER_W = 8;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Payload presented to the decoder.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus4;
    } fetch_pkt_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/t03_fetch_timer.sv
// Request timeout counter: clear has priority over count; expire_c flags the last allowed cycle.
module t03_fetch_timer
    import t03_fetch_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic count,
    output logic expire_c
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c = (cnt_q == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/t03_fetch.sv
// Instruction fetch stage: one-word req/ack fetch, redirect, stall, timeout and sticky fault.
// Define T03_FETCH_MISALIGN_TRAP_EN to fault on misaligned redirect targets instead of aligning them.
module t03_fetch
    import t03_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              en,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_fault
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0] ir_q, ir_d;
    fetch_pkt_t        pkt_q, pkt_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;

    logic              expire_c;
    logic              timer_clear_c;
    logic              timer_count_c;
    logic [ADDR_W-1:0] redir_tgt_c;
    logic              misalign_c;

`ifdef T03_FETCH_MISALIGN_TRAP_EN
    assign redir_tgt_c = redirect_pc;
    assign misalign_c  = |redirect_pc[1:0];
`else
    assign redir_tgt_c = word_align(redirect_pc);
    assign misalign_c  = 1'b0;
`endif

    // Timer runs only while a request is outstanding; an accepted ack or redirect restarts it.
    assign timer_count_c = (state_q == REQ);
    assign timer_clear_c = (state_q != REQ) || redirect || imem_ack;

    t03_fetch_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .nRst     (nRst),
        .clear    (timer_clear_c),
        .count    (timer_count_c),
        .expire_c (expire_c)
    );

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        ir_d           = ir_q;
        pkt_d          = pkt_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Redirect wins over a same-cycle ack; the returned word is dropped.
                if (redirect) begin
                    if (misalign_c) begin
                        state_d = FAULT;
                    end else begin
                        fetch_pc_d = redir_tgt_c;
                    end
                end else if (imem_ack) begin
                    ir_d       = imem_rdata;
                    pkt_d.pc   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                    state_d    = VALID;
                end else if (expire_c) begin
                    state_d = FAULT;
                end
            end
            VALID: begin
                if (redirect) begin
                    if (misalign_c) begin
                        state_d = FAULT;
                    end else begin
                        fetch_pc_d = redir_tgt_c;
                        state_d    = REQ;
                    end
                end else if (stall) begin
                    state_d = VALID;
                end else if (en) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        req_d          = (state_d == REQ);
        valid_d        = (state_d == VALID);
        fault_d        = (state_d == FAULT);
        pkt_d.inst     = (state_d == VALID) ? ir_d : NOP_INST;
        pkt_d.pc_plus4 = pkt_d.pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= IDLE;
            fetch_pc_q     <= RESET_PC;
            ir_q           <= NOP_INST;
            pkt_q.inst     <= NOP_INST;
            pkt_q.pc       <= RESET_PC;
            pkt_q.pc_plus4 <= RESET_PC + ADDR_W'(4);
            req_q          <= 1'b0;
            valid_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            pkt_q      <= pkt_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign inst        = pkt_q.inst;
    assign inst_valid  = valid_q;
    assign pc          = pkt_q.pc;
    assign pc_plus4    = pkt_q.pc_plus4;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_t03_fetch.sv
// Directed, table-driven bench for t03_fetch plus hand sequences for timeout, misalign and reset.
module tb_t03_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        nRst;
    logic        en;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    int n_chk;
    int n_fail;

    t03_fetch dut (
        .clk         (clk),
        .nRst        (nRst),
        .en          (en),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_fault;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic [31:0] e_pc4, input logic e_fault);
        chk({tag, ".imem_req"},    32'(imem_req),    32'(e_req));
        chk({tag, ".imem_addr"},   imem_addr,        e_addr);
        chk({tag, ".inst_valid"},  32'(inst_valid),  32'(e_valid));
        chk({tag, ".inst"},        inst,             e_inst);
        chk({tag, ".pc"},          pc,               e_pc);
        chk({tag, ".pc_plus4"},    pc_plus4,         e_pc4);
        chk({tag, ".fetch_fault"}, 32'(fetch_fault), 32'(e_fault));
    endtask

    task automatic drive(input logic e, input logic s, input logic r, input logic [31:0] rp,
                         input logic a, input logic [31:0] rd);
        en = e; stall = s; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nRst   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        //                 en    stall redir rpc           ack   rdata         req   addr          val   inst          pc            pc4           flt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, NOP,          32'h0,        32'h4,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, NOP,          32'h0,        32'h4,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h99999999, 1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 32'h00500093, 32'h0,        32'h4,        1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4,        1'b0, NOP,          32'h0,        32'h4,        1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h100,      1'b1, 32'hdeadbeef, 1'b1, 32'h100,      1'b0, NOP,          32'h0,        32'h4,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h00a00113, 1'b0, 32'h104,      1'b1, 32'h00a00113, 32'h100,      32'h104,      1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104,      1'b0, NOP,          32'h100,      32'h104,      1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h55555555, 1'b0, 32'h104,      1'b0, NOP,          32'h100,      32'h104,      1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 32'h104,      1'b0, NOP,          32'h100,      32'h104,      1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h104,      1'b0, NOP,          32'h100,      32'h104,      1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h108,      1'b1, 32'h11111111, 32'h104,      32'h108,      1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 32'h300,      1'b0, 32'h0,        1'b1, 32'h300,      1'b0, NOP,          32'h104,      32'h108,      1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h0,        1'b1, 32'hfffffffc, 1'b0, NOP,          32'h104,      32'h108,      1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0,        1'b1, 32'h22222222, 32'hfffffffc, 32'h0,        1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0,        1'b0, NOP,          32'hfffffffc, 32'h0,        1'b0};

        #12;
        chk_all("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        step();

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].en, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_fault);
        end

        // Misaligned redirect while a request is pending at address 0.
        drive(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
        step();
`ifdef T03_FETCH_MISALIGN_TRAP_EN
        chk("misalign.fault", 32'(fetch_fault), 32'h1);
        chk("misalign.req",   32'(imem_req),    32'h0);
`else
        chk("misalign.addr",  imem_addr,        32'h100);
        chk("misalign.req",   32'(imem_req),    32'h1);
        chk("misalign.fault", 32'(fetch_fault), 32'h0);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        nRst = 1'b0;
        #1;
        chk_all("rst_mid", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0);

        // Timeout: 255 request cycles without ack.
        @(negedge clk);
        nRst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("tmo.enter_req", 32'(imem_req), 32'h1);
        en = 1'b0;
        repeat (254) step();
        chk("tmo.req_254",   32'(imem_req),    32'h1);
        chk("tmo.fault_254", 32'(fetch_fault), 32'h0);
        step();
        chk_all("tmo.255", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h12345678);
        repeat (3) step();
        chk("tmo.sticky_fault", 32'(fetch_fault), 32'h1);
        chk("tmo.sticky_req",   32'(imem_req),    32'h0);
        chk("tmo.sticky_valid", 32'(inst_valid),  32'h0);
        chk("tmo.sticky_inst",  inst,             NOP);
        #2;
        nRst = 1'b0;
        #1;
        chk("tmo.rst_clears", 32'(fetch_fault), 32'h0);

        // Reset mid-request, then a late ack must not produce an instruction.
        @(negedge clk);
        nRst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("rst6.req", 32'(imem_req), 32'h1);
        #2;
        nRst = 1'b0;
        #1;
        chk_all("rst6.async", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'habcd0000);
        step();
        chk_all("rst6.held", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0);
        en = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        step();
        chk_all("rst6.late_ack", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
